ips2l_pcie_dma_rx_mwr_tlp_parse: RTL and testbench

IPS2L_PCIE_DMA_RX_MWR_TLP_PARSE -- requirements
Module: ips2l_pcie_dma_rx_mwr_tlp_parse

---
 rtl/ips2l_pcie_dma_rx_mwr_tlp_parse.sv | 226 ++++++++++++++++++++++
 tb/tb_ips2l_pcie_dma_rx_mwr_tlp_parse.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ips2l_pcie_dma_rx_mwr_tlp_parse.sv
// 128-bit RX TLP parser: decodes Memory Write headers, emits address/length/BE and per-DW payload strobes.
// Optional IPS2L_PCIE_DMA_MWR_POISON_DROP_EN: poisoned (EP=1) MWr TLPs are discarded like non-MWr TLPs.
module ips2l_pcie_dma_rx_mwr_tlp_parse (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_axis_rx_tvalid,
    output logic         o_axis_rx_tready,
    input  logic [127:0] i_axis_rx_tdata,
    input  logic         i_axis_rx_tlast,
    input  logic [1:0]   i_axis_rx_bar_hit,
    output logic         o_mwr_wr_start,
    output logic [9:0]   o_mwr_length,
    output logic [7:0]   o_mwr_dwbe,
    output logic [63:0]  o_mwr_addr,
    output logic [1:0]   o_bar_hit,
    output logic [127:0] o_mwr_data,
    output logic [3:0]   o_mwr_dw_vld,
    output logic         o_len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [10:0]    remain_r;
    logic [10:0]    remain_s;
    logic           tready_r;

    logic           start_r;
    logic [9:0]     length_r;
    logic [7:0]     dwbe_r;
    logic [63:0]    addr_r;
    logic [1:0]     bar_r;
    logic [127:0]   data_r;
    logic [3:0]     dw_vld_r;
    logic           len_err_r;

    logic           start_s;
    logic [9:0]     length_s;
    logic [7:0]     dwbe_s;
    logic [63:0]    addr_s;
    logic [1:0]     bar_s;
    logic [3:0]     dw_vld_s;
    logic           len_err_s;

    logic           beat_s;
    logic [31:0]    dw0_s;
    logic [31:0]    dw1_s;
    logic [31:0]    dw2_s;
    logic [31:0]    dw3_s;
    logic           ep_drop_s;
    logic           is_mwr_s;
    logic [10:0]    len_ext_s;
    logic [10:0]    hdr_rem_s;
    logic [2:0]     take_s;
    logic [10:0]    rem_next_s;

    // DWs consumed by one data beat: min(4, remaining)
    function automatic logic [2:0] lane_take(input logic [10:0] rem);
        if (rem >= 11'd4) begin
            lane_take = 3'd4;
        end else begin
            lane_take = rem[2:0];
        end
    endfunction

    // Low-lane strobe mask for a DW count
    function automatic logic [3:0] lane_mask(input logic [2:0] take);
        case (take)
            3'd4:    lane_mask = 4'b1111;
            3'd3:    lane_mask = 4'b0111;
            3'd2:    lane_mask = 4'b0011;
            3'd1:    lane_mask = 4'b0001;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    assign beat_s = i_axis_rx_tvalid & tready_r;
    assign dw0_s  = i_axis_rx_tdata[31:0];
    assign dw1_s  = i_axis_rx_tdata[63:32];
    assign dw2_s  = i_axis_rx_tdata[95:64];
    assign dw3_s  = i_axis_rx_tdata[127:96];

`ifdef IPS2L_PCIE_DMA_MWR_POISON_DROP_EN
    assign ep_drop_s = dw0_s[14];
`else
    assign ep_drop_s = 1'b0;
`endif

    assign is_mwr_s = ((dw0_s[31:29] == 3'b010) || (dw0_s[31:29] == 3'b011)) &&
                      (dw0_s[28:24] == 5'b00000) && !ep_drop_s;

    // Length field 0 encodes the 1024-DW maximum
    assign len_ext_s  = (dw0_s[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0_s[9:0]};
    assign hdr_rem_s  = dw0_s[29] ? len_ext_s : (len_ext_s - 11'd1);
    assign take_s     = lane_take(remain_r);
    assign rem_next_s = remain_r - {8'd0, take_s};

    // State and remaining-DW counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            remain_r <= 11'd0;
            tready_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            remain_r <= remain_s;
            tready_r <= 1'b1;
        end
    end

    // Next-state, counter and next-output decode
    always_comb begin
        state_s   = state_r;
        remain_s  = remain_r;
        start_s   = 1'b0;
        length_s  = length_r;
        dwbe_s    = dwbe_r;
        addr_s    = addr_r;
        bar_s     = bar_r;
        dw_vld_s  = 4'b0000;
        len_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    if (is_mwr_s) begin
                        start_s  = 1'b1;
                        length_s = dw0_s[9:0];
                        dwbe_s   = dw1_s[7:0];
                        bar_s    = i_axis_rx_bar_hit;
                        if (dw0_s[29]) begin
                            addr_s   = {dw2_s, dw3_s[31:2], 2'b00};
                            dw_vld_s = 4'b0000;
                        end else begin
                            addr_s   = {32'h0000_0000, dw2_s[31:2], 2'b00};
                            dw_vld_s = 4'b1000;
                        end
                        if (i_axis_rx_tlast) begin
                            state_s   = IDLE;
                            remain_s  = 11'd0;
                            len_err_s = (hdr_rem_s != 11'd0);
                        end else begin
                            state_s   = DATA;
                            remain_s  = hdr_rem_s;
                            len_err_s = (hdr_rem_s == 11'd0);
                        end
                    end else begin
                        if (i_axis_rx_tlast) begin
                            state_s = IDLE;
                        end else begin
                            state_s = DROP;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (beat_s) begin
                    dw_vld_s = lane_mask(take_s);
                    if (i_axis_rx_tlast) begin
                        state_s   = IDLE;
                        remain_s  = 11'd0;
                        len_err_s = (rem_next_s != 11'd0);
                    end else begin
                        state_s   = DATA;
                        remain_s  = rem_next_s;
                        // Flag only the beat that exhausts the count early
                        len_err_s = (remain_r != 11'd0) && (rem_next_s == 11'd0);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            DROP: begin
                if (beat_s && i_axis_rx_tlast) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s  = IDLE;
                remain_s = 11'd0;
            end
        endcase
    end

    // Registered outputs, one cycle after the accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            start_r   <= 1'b0;
            length_r  <= 10'd0;
            dwbe_r    <= 8'd0;
            addr_r    <= 64'd0;
            bar_r     <= 2'd0;
            data_r    <= 128'd0;
            dw_vld_r  <= 4'd0;
            len_err_r <= 1'b0;
        end else begin
            start_r   <= start_s;
            length_r  <= length_s;
            dwbe_r    <= dwbe_s;
            addr_r    <= addr_s;
            bar_r     <= bar_s;
            data_r    <= beat_s ? i_axis_rx_tdata : data_r;
            dw_vld_r  <= dw_vld_s;
            len_err_r <= len_err_s;
        end
    end

    assign o_axis_rx_tready = tready_r;
    assign o_mwr_wr_start   = start_r;
    assign o_mwr_length     = length_r;
    assign o_mwr_dwbe       = dwbe_r;
    assign o_mwr_addr       = addr_r;
    assign o_bar_hit        = bar_r;
    assign o_mwr_data       = data_r;
    assign o_mwr_dw_vld     = dw_vld_r;
    assign o_len_err        = len_err_r;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_mwr_tlp_parse.sv
// Directed testbench for ips2l_pcie_dma_rx_mwr_tlp_parse with hand-computed expectations.
module tb_ips2l_pcie_dma_rx_mwr_tlp_parse;

    logic         clk;
    logic         rst;
    logic         tvalid;
    logic         tready;
    logic [127:0] tdata;
    logic         tlast;
    logic [1:0]   bar_hit;
    logic         wr_start;
    logic [9:0]   length;
    logic [7:0]   dwbe;
    logic [63:0]  addr;
    logic [1:0]   bar_out;
    logic [127:0] mdata;
    logic [3:0]   dw_vld;
    logic         len_err;

    int n_vec;
    int n_err;
    logic [127:0] hdr;

    ips2l_pcie_dma_rx_mwr_tlp_parse dut (
        .clk               (clk),
        .rst               (rst),
        .i_axis_rx_tvalid  (tvalid),
        .o_axis_rx_tready  (tready),
        .i_axis_rx_tdata   (tdata),
        .i_axis_rx_tlast   (tlast),
        .i_axis_rx_bar_hit (bar_hit),
        .o_mwr_wr_start    (wr_start),
        .o_mwr_length      (length),
        .o_mwr_dwbe        (dwbe),
        .o_mwr_addr        (addr),
        .o_bar_hit         (bar_out),
        .o_mwr_data        (mdata),
        .o_mwr_dw_vld      (dw_vld),
        .o_len_err         (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {DW3, DW2, DW1, DW0} with EP at DW0[14]
    function automatic logic [127:0] mk_hdr(input logic [7:0] ft, input logic ep, input logic [9:0] len,
                                            input logic [7:0] be, input logic [31:0] d2, input logic [31:0] d3);
        mk_hdr = {d3, d2, 24'h000000, be, ft, 9'h000, ep, 4'h0, len};
    endfunction

    task automatic beat(input logic [127:0] d, input logic last, input logic [1:0] bh);
        tvalid  = 1'b1;
        tdata   = d;
        tlast   = last;
        bar_hit = bh;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        tvalid  = 1'b0;
        tdata   = 128'd0;
        tlast   = 1'b0;
        bar_hit = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", {127'd0, tready}, 128'd0);
        chk("rst_start", {127'd0, wr_start}, 128'd0);
        chk("rst_addr", {64'd0, addr}, 128'd0);
        chk("rst_dwvld", {124'd0, dw_vld}, 128'd0);
        rst = 1'b0;
        chk("post_rst_tready0", {127'd0, tready}, 128'd0);
        @(posedge clk);
        #1;
        chk("post_rst_tready1", {127'd0, tready}, 128'd1);

        // 3DW MWr Length=1, single beat
        hdr = mk_hdr(8'h40, 1'b0, 10'd1, 8'h0F, 32'h0000_1004, 32'hDEAD_BEEF);
        beat(hdr, 1'b1, 2'b01);
        chk("s1_start", {127'd0, wr_start}, 128'd1);
        chk("s1_addr", {64'd0, addr}, 128'h1004);
        chk("s1_dwbe", {120'd0, dwbe}, 128'h0F);
        chk("s1_dwvld", {124'd0, dw_vld}, 128'b1000);
        chk("s1_bar", {126'd0, bar_out}, 128'b01);
        chk("s1_len", {118'd0, length}, 128'd1);
        chk("s1_data", mdata, hdr);
        chk("s1_lenerr", {127'd0, len_err}, 128'd0);
        idle();
        chk("s1_idle_start", {127'd0, wr_start}, 128'd0);
        chk("s1_idle_dwvld", {124'd0, dw_vld}, 128'd0);
        chk("s1_idle_addr_held", {64'd0, addr}, 128'h1004);

        // 4DW MWr Length=6 over 3 beats with a mid-TLP gap
        beat(mk_hdr(8'h60, 1'b0, 10'd6, 8'hFF, 32'h0000_0001, 32'h0000_2000), 1'b0, 2'b10);
        chk("s2_start", {127'd0, wr_start}, 128'd1);
        chk("s2_dwvld0", {124'd0, dw_vld}, 128'b0000);
        chk("s2_addr", {64'd0, addr}, 128'h1_0000_2000);
        beat({32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 2'b00);
        chk("s2_dwvld1", {124'd0, dw_vld}, 128'b1111);
        chk("s2_start1", {127'd0, wr_start}, 128'd0);
        idle();
        chk("s2_gap_dwvld", {124'd0, dw_vld}, 128'b0000);
        beat({32'h8, 32'h7, 32'h6, 32'h5}, 1'b1, 2'b00);
        chk("s2_dwvld2", {124'd0, dw_vld}, 128'b0011);
        chk("s2_lenerr", {127'd0, len_err}, 128'd0);
        chk("s2_data", mdata, {32'h8, 32'h7, 32'h6, 32'h5});

        // MRd then back-to-back 3DW MWr Length=5
        beat(mk_hdr(8'h00, 1'b0, 10'd1, 8'h0F, 32'h0000_9000, 32'h0), 1'b1, 2'b01);
        chk("s3_mrd_start", {127'd0, wr_start}, 128'd0);
        chk("s3_mrd_dwvld", {124'd0, dw_vld}, 128'd0);
        chk("s3_mrd_addr_held", {64'd0, addr}, 128'h1_0000_2000);
        beat(mk_hdr(8'h40, 1'b0, 10'd5, 8'hFF, 32'h0000_3008, 32'hA), 1'b0, 2'b01);
        chk("s3_start", {127'd0, wr_start}, 128'd1);
        chk("s3_dwvld0", {124'd0, dw_vld}, 128'b1000);
        chk("s3_addr", {64'd0, addr}, 128'h3008);
        beat({32'hE, 32'hD, 32'hC, 32'hB}, 1'b1, 2'b00);
        chk("s3_dwvld1", {124'd0, dw_vld}, 128'b1111);
        chk("s3_lenerr", {127'd0, len_err}, 128'd0);

        // Length=8 truncated by early tlast, then a clean header
        beat(mk_hdr(8'h40, 1'b0, 10'd8, 8'hFF, 32'h0000_4000, 32'h1), 1'b0, 2'b01);
        chk("s4_lenerr0", {127'd0, len_err}, 128'd0);
        beat({32'h5, 32'h4, 32'h3, 32'h2}, 1'b1, 2'b00);
        chk("s4_dwvld1", {124'd0, dw_vld}, 128'b1111);
        chk("s4_lenerr1", {127'd0, len_err}, 128'd1);
        beat(mk_hdr(8'h40, 1'b0, 10'd1, 8'h03, 32'h0000_5000, 32'h9), 1'b1, 2'b10);
        chk("s4_next_start", {127'd0, wr_start}, 128'd1);
        chk("s4_next_addr", {64'd0, addr}, 128'h5000);
        chk("s4_next_lenerr", {127'd0, len_err}, 128'd0);

        // Length=2 overrun: count exhausted before tlast
        beat(mk_hdr(8'h40, 1'b0, 10'd2, 8'h0F, 32'h0000_5800, 32'h1), 1'b0, 2'b01);
        chk("s5_addr", {64'd0, addr}, 128'h5800);
        beat({32'h0, 32'h0, 32'h0, 32'h2}, 1'b0, 2'b00);
        chk("s5_dwvld1", {124'd0, dw_vld}, 128'b0001);
        chk("s5_lenerr1", {127'd0, len_err}, 128'd1);
        beat({32'h0, 32'h0, 32'h0, 32'h3}, 1'b1, 2'b00);
        chk("s5_dwvld2", {124'd0, dw_vld}, 128'b0000);
        chk("s5_lenerr2", {127'd0, len_err}, 128'd0);
        chk("s5_start2", {127'd0, wr_start}, 128'd0);

        // Poisoned MWr
        beat(mk_hdr(8'h40, 1'b1, 10'd1, 8'h0F, 32'h0000_6000, 32'h7), 1'b1, 2'b01);
`ifdef IPS2L_PCIE_DMA_MWR_POISON_DROP_EN
        chk("s6_ep_start", {127'd0, wr_start}, 128'd0);
        chk("s6_ep_dwvld", {124'd0, dw_vld}, 128'b0000);
        chk("s6_ep_addr_held", {64'd0, addr}, 128'h5800);
`else
        chk("s6_ep_start", {127'd0, wr_start}, 128'd1);
        chk("s6_ep_dwvld", {124'd0, dw_vld}, 128'b1000);
        chk("s6_ep_addr", {64'd0, addr}, 128'h6000);
`endif

        // Multi-beat completion whose second beat mimics an MWr header
        beat(mk_hdr(8'h4A, 1'b0, 10'd4, 8'h00, 32'h0, 32'h0), 1'b0, 2'b00);
        chk("s7_cpl_start", {127'd0, wr_start}, 128'd0);
        beat(mk_hdr(8'h40, 1'b0, 10'd1, 8'h0F, 32'h0000_A000, 32'h0), 1'b1, 2'b00);
        chk("s7_drop_start", {127'd0, wr_start}, 128'd0);
        chk("s7_drop_dwvld", {124'd0, dw_vld}, 128'b0000);

        // 4DW Length=0 (1024 DW) ended on its header beat
        beat(mk_hdr(8'h60, 1'b0, 10'd0, 8'hFF, 32'h0, 32'h0000_B000), 1'b1, 2'b11);
        chk("s8_start", {127'd0, wr_start}, 128'd1);
        chk("s8_lenerr", {127'd0, len_err}, 128'd1);
        chk("s8_len", {118'd0, length}, 128'd0);

        // Reset in the middle of a 4-beat MWr
        beat(mk_hdr(8'h60, 1'b0, 10'd12, 8'hFF, 32'h2, 32'h0000_C000), 1'b0, 2'b01);
        chk("s9_start", {127'd0, wr_start}, 128'd1);
        tvalid = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("s9_rst_addr", {64'd0, addr}, 128'd0);
        chk("s9_rst_bar", {126'd0, bar_out}, 128'd0);
        chk("s9_rst_tready", {127'd0, tready}, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        beat(mk_hdr(8'h40, 1'b0, 10'd1, 8'h0F, 32'h0000_7000, 32'h5), 1'b1, 2'b10);
        chk("s9_start2", {127'd0, wr_start}, 128'd1);
        chk("s9_addr2", {64'd0, addr}, 128'h7000);
        chk("s9_dwvld2", {124'd0, dw_vld}, 128'b1000);
        chk("s9_bar2", {126'd0, bar_out}, 128'b10);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
